// File: rtl/pulse_expander.sv
// pulse_expander
//   Expands one-cycle event pulses into visible level windows. Each event
//   gives HOLD_CYCLES of level_o high, then GAP_CYCLES of level_o low.
//   Events that arrive while a window or gap is running are counted and
//   played back one after another.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   pulse_i    event request; every high cycle is one event
//   level_o    expanded level (registered)
//   busy_o     high while a window or gap is in progress (registered)
//   pending_o  number of queued events not yet started (registered)
//   overflow_o sticky, set when an event is dropped on a full queue
module pulse_expander #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PEND_W-1:0] pend_reg, pend_next;
  logic              ovf_reg, ovf_next;
  logic              level_reg, busy_reg;

  logic hold_done;
  logic gap_done;
  logic pend_inc;
  logic pend_dec;

  assign hold_done = (cnt_reg == HOLD_LAST);
  assign gap_done  = (cnt_reg == GAP_LAST);

  // A pulse on the final gap cycle with an empty queue restarts HOLD
  // directly instead of being queued; every other pulse outside IDLE queues.
  assign pend_dec = (state_reg == GAP) && gap_done && (pend_reg != '0);
  assign pend_inc = pulse_i &&
                    ((state_reg == HOLD) ||
                     ((state_reg == GAP) && !(gap_done && (pend_reg == '0))));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    pend_next  = pend_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (pulse_i) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_next = GAP;
          cnt_next   = '0;
        end
      end
      GAP: begin
        if (gap_done) begin
          cnt_next = '0;
          if ((pend_reg != '0) || pulse_i) begin
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Simultaneous increment and decrement cancel out.
    case ({pend_inc, pend_dec})
      2'b10: begin
        if (pend_reg == PEND_MAX) begin
          ovf_next = 1'b1;
        end else begin
          pend_next = pend_reg + PEND_W'(1);
        end
      end
      2'b01:   pend_next = pend_reg - PEND_W'(1);
      default: pend_next = pend_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= '0;
      ovf_reg   <= 1'b0;
      level_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      ovf_reg   <= ovf_next;
      // Outputs are registered from the next state so they line up with it.
      level_reg <= (state_next == HOLD);
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign level_o    = level_reg;
  assign busy_o     = busy_reg;
  assign pending_o  = pend_reg;
  assign overflow_o = ovf_reg;

endmodule

// File: tb/tb_pulse_expander.sv
// Testbench for pulse_expander. Two instances: dut_a with default
// parameters, dut_b with HOLD_CYCLES=16 for the saturation case.
// Cycle numbers are relative to the cycle right after a reset release.
module tb_pulse_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, pulse_a = 1'b0, level_a, busy_a, ovf_a;
  logic [2:0] pend_a;
  logic       rst_b = 1'b1, pulse_b = 1'b0, level_b, busy_b, ovf_b;
  logic [2:0] pend_b;

  pulse_expander dut_a (
    .clk(clk), .rst(rst_a), .pulse_i(pulse_a), .level_o(level_a),
    .busy_o(busy_a), .pending_o(pend_a), .overflow_o(ovf_a)
  );

  pulse_expander #(.HOLD_CYCLES(16), .GAP_CYCLES(2), .PEND_W(3)) dut_b (
    .clk(clk), .rst(rst_b), .pulse_i(pulse_b), .level_o(level_b),
    .busy_o(busy_b), .pending_o(pend_b), .overflow_o(ovf_b)
  );

  int cyc  = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start;
    int len;
  } win_t;
  win_t exp_a[$];
  win_t exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Window monitors: measure each high window of level_o and compare it
  // against the next expected window in the queue.
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   start_a = 0, start_b = 0;

  always @(negedge clk) begin
    win_t w;
    if (level_a && !prev_a) start_a = cyc - base;
    if (!level_a && prev_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_window: got start=%0d len=%0d expected none",
                 start_a, cyc - base - start_a);
      end else begin
        w = exp_a.pop_front();
        $display("window dut_a start=%0d len=%0d (exp start=%0d len=%0d)",
                 start_a, cyc - base - start_a, w.start, w.len);
        chk("a_window_start", start_a, w.start);
        chk("a_window_len", cyc - base - start_a, w.len);
      end
    end
    prev_a = level_a;
  end

  always @(negedge clk) begin
    win_t w;
    if (level_b && !prev_b) start_b = cyc - base;
    if (!level_b && prev_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_window: got start=%0d len=%0d expected none",
                 start_b, cyc - base - start_b);
      end else begin
        w = exp_b.pop_front();
        $display("window dut_b start=%0d len=%0d (exp start=%0d len=%0d)",
                 start_b, cyc - base - start_b, w.start, w.len);
        chk("b_window_start", start_b, w.start);
        chk("b_window_len", cyc - base - start_b, w.len);
      end
    end
    prev_b = level_b;
  end

  task automatic push_a(input int s, input int l);
    win_t w;
    w.start = s; w.len = l;
    exp_a.push_back(w);
  endtask

  task automatic push_b(input int s, input int l);
    win_t w;
    w.start = s; w.len = l;
    exp_b.push_back(w);
  endtask

  // Reset one instance; returns at the negedge of relative cycle 0.
  task automatic reset_dut(input bit sel_b);
    @(negedge clk);
    if (sel_b) rst_b = 1'b1; else rst_a = 1'b1;
    @(negedge clk);
    if (sel_b) rst_b = 1'b0; else rst_a = 1'b0;
    base = cyc;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  // Wait for the expected windows to be consumed and the DUT to go idle.
  task automatic drain(input bit sel_b, input int budget);
    int n = 0;
    while (n < budget && ((sel_b ? exp_b.size() : exp_a.size()) != 0 ||
                          (sel_b ? busy_b : busy_a))) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d windows outstanding expected 0",
               sel_b ? exp_b.size() : exp_a.size());
      exp_a.delete();
      exp_b.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: single pulse at cycle 10.
    reset_dut(1'b0);
    chk("rst_level", level_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pending", pend_a, 0);
    chk("rst_overflow", ovf_a, 0);
    push_a(11, 4);
    for (int c = 10; c <= 18; c++) begin
      wait_rel(c);
      pulse_a = (c == 10);
      chk("t1_busy", busy_a, (c >= 11 && c <= 16));
      chk("t1_pending", pend_a, 0);
    end
    pulse_a = 1'b0;
    chk("t1_overflow", ovf_a, 0);
    drain(1'b0, 50);

    // Test 2: pulses at 10, 12, 13 queue two events.
    reset_dut(1'b0);
    push_a(11, 4); push_a(17, 4); push_a(23, 4);
    for (int c = 10; c <= 30; c++) begin
      wait_rel(c);
      pulse_a = (c == 10 || c == 12 || c == 13);
      if (c == 13) chk("t2_pend_c13", pend_a, 1);
      if (c == 14) chk("t2_pend_c14", pend_a, 2);
      if (c == 16) chk("t2_pend_c16", pend_a, 2);
      if (c == 17) chk("t2_pend_c17", pend_a, 1);
      if (c == 23) chk("t2_pend_c23", pend_a, 0);
      if (c == 28) chk("t2_busy_c28", busy_a, 1);
      if (c == 29) chk("t2_busy_c29", busy_a, 0);
    end
    pulse_a = 1'b0;
    drain(1'b0, 50);

    // Test 3: pulse on the last gap cycle is consumed directly.
    reset_dut(1'b0);
    push_a(11, 4); push_a(17, 4);
    for (int c = 10; c <= 24; c++) begin
      wait_rel(c);
      pulse_a = (c == 10 || c == 16);
      if (c >= 11 && c <= 22) chk("t3_busy_hold", busy_a, 1);
      if (c == 23) chk("t3_busy_end", busy_a, 0);
      chk("t3_pending", pend_a, 0);
    end
    pulse_a = 1'b0;
    drain(1'b0, 50);

    // Test 4: reset mid-operation discards the queue.
    reset_dut(1'b0);
    push_a(11, 3); push_a(21, 4);
    for (int c = 10; c <= 27; c++) begin
      wait_rel(c);
      pulse_a = (c == 10 || c == 11 || c == 12 || c == 20);
      rst_a   = (c == 13);
      if (c == 13) chk("t4_pend_before_rst", pend_a, 2);
      if (c == 14) begin
        chk("t4_level", level_a, 0);
        chk("t4_busy", busy_a, 0);
        chk("t4_pending", pend_a, 0);
        chk("t4_overflow", ovf_a, 0);
      end
    end
    pulse_a = 1'b0;
    rst_a   = 1'b0;
    drain(1'b0, 50);

    // Test 5: reset wins over a simultaneous pulse.
    reset_dut(1'b0);
    for (int c = 10; c <= 21; c++) begin
      wait_rel(c);
      pulse_a = (c == 10);
      rst_a   = (c == 10);
      if (c >= 11 && c <= 20) begin
        chk("t5_level", level_a, 0);
        chk("t5_busy", busy_a, 0);
      end
    end
    pulse_a = 1'b0;
    rst_a   = 1'b0;
    drain(1'b0, 50);

    // Test 6: HOLD_CYCLES=16, pulse held 10..18 saturates the queue.
    reset_dut(1'b1);
    for (int k = 0; k < 8; k++) push_b(11 + 18 * k, 16);
    for (int c = 10; c <= 20; c++) begin
      wait_rel(c);
      pulse_b = (c >= 10 && c <= 18);
      if (c == 17) chk("t6_pend_c17", pend_b, 6);
      if (c == 18) begin
        chk("t6_pend_c18", pend_b, 7);
        chk("t6_ovf_c18", ovf_b, 0);
      end
      if (c == 19) begin
        chk("t6_pend_c19", pend_b, 7);
        chk("t6_ovf_c19", ovf_b, 1);
      end
    end
    pulse_b = 1'b0;
    drain(1'b1, 400);
    chk("t6_ovf_sticky", ovf_b, 1);
    chk("t6_pend_final", pend_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
